// File: rtl/fdu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fdu_pkg
// Description : Shared definitions for both ends of the FDU heartbeat link:
//               state encodings, the 3-bit Gray rolling-code step and the
//               default timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package fdu_pkg;

  // State encoding, visible on state_out for LEDs/debug
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_STALLED  = 2'b10,
    ST_POR_HOLD = 2'b11
  } fdu_state_t;

  // Default timing at 50 MHz: 100 ms beat, 500 ms kick timeout
  localparam int DEF_BEAT_PERIOD  = 5000000;
  localparam int DEF_KICK_TIMEOUT = 25000000;

  // Next heartbeat code: 000>001>011>010>110>111>101>100>000
  function automatic logic [2:0] gray_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b000:  nxt = 3'b001;
      3'b001:  nxt = 3'b011;
      3'b011:  nxt = 3'b010;
      3'b010:  nxt = 3'b110;
      3'b110:  nxt = 3'b111;
      3'b111:  nxt = 3'b101;
      3'b101:  nxt = 3'b100;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdu_heartbeat_tx_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for a single asynchronous level,
//               synchronous active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input into the clk domain
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/fdu_heartbeat_tx.sv
`default_nettype none
// ============================================================================
// Module      : fdu_heartbeat_tx
// Description : Processor-side FDU heartbeat transmitter. Steps a 3-bit Gray
//               code every BEAT_PERIOD cycles while software keeps kicking,
//               freezes the code when kicks stop, and parks at 000 while the
//               FDU requests POR. Reports the synchronized prime line.
// Revision    : 1.0 - initial release
// ============================================================================
module fdu_heartbeat_tx
  import fdu_pkg::*;
#(
  parameter int BEAT_PERIOD  = DEF_BEAT_PERIOD,
  parameter int KICK_TIMEOUT = DEF_KICK_TIMEOUT,
  parameter int CNT_W        = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       kick,
  input  logic       prime_in,
  input  logic       por_in,
  output logic [2:0] hb_code,
  output logic       is_prime,
  output logic       stalled,
  output logic [1:0] state_out
);

  localparam logic [CNT_W-1:0] c_BEAT_LAST = CNT_W'(BEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_KICK_LAST = CNT_W'(KICK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  fdu_state_t       r_state;
  fdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_nxt;
  logic [CNT_W-1:0] r_kick_cnt;
  logic [CNT_W-1:0] w_kick_nxt;
  logic [2:0]       r_code;
  logic [2:0]       w_code_nxt;
  logic             w_por;
  logic             w_prime;
  logic             w_kick_done;
  logic             w_beat_done;

  sync2 u_sync_prime (
    .clk   (clk),
    .reset (reset),
    .i_d   (prime_in),
    .o_q   (w_prime)
  );

  sync2 u_sync_por (
    .clk   (clk),
    .reset (reset),
    .i_d   (por_in),
    .o_q   (w_por)
  );

  assign w_kick_done = (r_kick_cnt == c_KICK_LAST);
  assign w_beat_done = (r_beat_cnt == c_BEAT_LAST);

  // Next-state, counter and code decisions in priority order: por > enable > kick > timeout > beat
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_kick_nxt  = r_kick_cnt;
    w_code_nxt  = r_code;
    case (r_state)
      ST_IDLE: begin
        w_beat_nxt = '0;
        w_kick_nxt = '0;
        w_code_nxt = 3'b000;
        if (enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_por) begin
          w_state_nxt = ST_POR_HOLD;
          w_beat_nxt  = '0;
          w_kick_nxt  = '0;
          w_code_nxt  = 3'b000;
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
          w_beat_nxt  = '0;
          w_kick_nxt  = '0;
          w_code_nxt  = 3'b000;
        end else if (!kick && w_kick_done) begin
          // Timeout: freeze code and counters so the watchdog sees no activity
          w_state_nxt = ST_STALLED;
        end else begin
          w_kick_nxt = kick ? '0 : (r_kick_cnt + c_ONE);
          if (w_beat_done) begin
            w_beat_nxt = '0;
            w_code_nxt = gray_next(r_code);
          end else begin
            w_beat_nxt = r_beat_cnt + c_ONE;
          end
        end
      end
      ST_STALLED: begin
        if (w_por) begin
          w_state_nxt = ST_POR_HOLD;
          w_beat_nxt  = '0;
          w_kick_nxt  = '0;
          w_code_nxt  = 3'b000;
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
          w_beat_nxt  = '0;
          w_kick_nxt  = '0;
          w_code_nxt  = 3'b000;
        end else if (kick) begin
          // Resume from the frozen code with a fresh beat and timeout window
          w_state_nxt = ST_RUN;
          w_beat_nxt  = '0;
          w_kick_nxt  = '0;
        end
      end
      ST_POR_HOLD: begin
        w_beat_nxt = '0;
        w_kick_nxt = '0;
        w_code_nxt = 3'b000;
        if (!w_por) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = '0;
        w_kick_nxt  = '0;
        w_code_nxt  = 3'b000;
      end
    endcase
  end

  // State, counter and code registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_kick_cnt <= '0;
      r_code     <= 3'b000;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_kick_cnt <= w_kick_nxt;
      r_code     <= w_code_nxt;
    end
  end

  assign hb_code   = r_code;
  assign state_out = r_state;
  assign stalled   = (r_state == ST_STALLED);
  assign is_prime  = w_prime;

endmodule
`default_nettype wire

// File: tb/tb_fdu_heartbeat_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fdu_heartbeat_tx
// Description : Self-checking bench for fdu_heartbeat_tx. A driver applies
//               directed and random stimulus and pushes the reference model's
//               expected outputs; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdu_heartbeat_tx;

  localparam int BP = 4;
  localparam int KT = 20;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STALL = 2;
  localparam int M_POR   = 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       kick;
  logic       prime_in;
  logic       por_in;
  logic [2:0] hb_code;
  logic       is_prime;
  logic       stalled;
  logic [1:0] state_out;

  typedef struct packed {
    logic [2:0] hb;
    logic [1:0] st;
    logic       stl;
    logic       pr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  // Reference: the heartbeat sequence as a table, position tracked by index
  logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  int m_mode, m_idx, m_beat, m_since;
  bit m_po1, m_po2, m_pr1, m_pr2;

  fdu_heartbeat_tx #(
    .BEAT_PERIOD  (BP),
    .KICK_TIMEOUT (KT),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .kick      (kick),
    .prime_in  (prime_in),
    .por_in    (por_in),
    .hb_code   (hb_code),
    .is_prime  (is_prime),
    .stalled   (stalled),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge of behaviour, applied to the inputs sampled on that edge
  function automatic void model_step(bit r, bit e, bit k, bit p, bit q);
    bit por_s;
    if (!r) begin
      m_mode = M_IDLE; m_idx = 0; m_beat = 0; m_since = 0;
      m_po1 = 0; m_po2 = 0; m_pr1 = 0; m_pr2 = 0;
      return;
    end
    por_s = m_po2;
    m_po2 = m_po1; m_po1 = q;
    m_pr2 = m_pr1; m_pr1 = p;
    if (m_mode == M_IDLE) begin
      if (e) begin m_mode = M_RUN; m_idx = 0; m_beat = 0; m_since = 0; end
    end else if (por_s) begin
      m_mode = M_POR; m_idx = 0; m_beat = 0; m_since = 0;
    end else if (m_mode == M_POR) begin
      m_mode = M_IDLE;
    end else if (!e) begin
      m_mode = M_IDLE; m_idx = 0; m_beat = 0; m_since = 0;
    end else if (m_mode == M_STALL) begin
      if (k) begin m_mode = M_RUN; m_beat = 0; m_since = 0; end
    end else begin
      if (!k && m_since == KT - 1) begin
        m_mode = M_STALL;
      end else begin
        m_since = k ? 0 : m_since + 1;
        m_beat  = m_beat + 1;
        if (m_beat == BP) begin
          m_beat = 0;
          m_idx  = (m_idx + 1) % 8;
        end
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit k, input bit p, input bit q);
    exp_t x;
    reset = r; enable = e; kick = k; prime_in = p; por_in = q;
    @(posedge clk);
    model_step(r, e, k, p, q);
    x.hb  = (m_mode == M_RUN || m_mode == M_STALL) ? seq[m_idx] : 3'b000;
    x.st  = 2'(m_mode);
    x.stl = (m_mode == M_STALL);
    x.pr  = m_pr2;
    sb.push_back(x);
    #1;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_checks++;
        if (hb_code !== x.hb || state_out !== x.st || stalled !== x.stl || is_prime !== x.pr) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t: hb=%b st=%b stl=%b pr=%b, required hb=%b st=%b stl=%b pr=%b",
                   $time, hb_code, state_out, stalled, is_prime, x.hb, x.st, x.stl, x.pr);
        end
      end
    end
  end

  initial begin
    bit pr;
    reset = 1'b0; enable = 1'b0; kick = 1'b0; prime_in = 1'b0; por_in = 1'b0;
    #1;
    // Reset, with prime toggling underneath
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, i[0], 0);
    // Run with a kick every 10 cycles through a full code wrap
    for (int i = 0; i < 40; i++) cyc(1, 1, (i % 10) == 0, $urandom_range(0, 1), 0);
    // Kicks stop: stall, hold, then resume with a kick
    for (int i = 0; i < 45; i++) cyc(1, 1, 0, $urandom_range(0, 1), 0);
    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1, 0);
    // Kick lands exactly on the timeout cycle
    for (int j = 0; j < 3; j++) begin
      cyc(1, 1, 1, 0, 0);
      for (int i = 0; i < 19; i++) cyc(1, 1, 0, $urandom_range(0, 1), 0);
    end
    cyc(1, 1, 1, 0, 0);
    // POR pulse for 10 cycles in RUN, then software re-enable
    for (int i = 0; i < 10; i++) cyc(1, 1, (i % 5) == 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, (i % 6) == 0, 0, 0);
    // Enable drop while stalled
    for (int i = 0; i < 25; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 1, 0);
    // Reset mid-RUN with por and kick active
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 1);
    cyc(0, 1, 1, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 1, 0);
    // Random mix
    pr = 0;
    for (int i = 0; i < 800; i++) begin
      bit q;
      if ($urandom_range(0, 99) < 30) pr = ~pr;
      q = ($urandom_range(0, 99) < 4) ? ~por_in : por_in;
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 99) >= 3,
          $urandom_range(0, 99) < 7,
          pr, q);
    end
    stim_done = 1;
  end

  // End-of-test: drain the scoreboard within a bounded number of cycles
  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
